// File: rtl/neural_layer_engine_if.sv
// neural_layer_engine_if: CPU slave bus bundle for the neural layer engine.
// The master drives strobes, address and write data; the slave returns
// registered read data and the level-sensitive done flag.
interface neural_layer_engine_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 9
);
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  writedata;
    logic [WIDTH-1:0]  readdata;
    logic              done;

    modport master (
        output write,
        output read,
        output address,
        output writedata,
        input  readdata,
        input  done
    );

    modport slave (
        input  write,
        input  read,
        input  address,
        input  writedata,
        output readdata,
        output done
    );
endinterface

// File: rtl/neural_layer_engine.sv
// neural_layer_engine: bus-mapped fully-connected layer. One shared MAC walks
// every neuron's weights, then one shared activation unit writes y[n].
// Optional feature macro: NLE_RELU_EN adds a ReLU activation selected by
// CTRL.MODE (sampled at START, readable as STATUS bit3).
module neural_layer_engine #(
    parameter int WIDTH       = 32,
    parameter int FRAC        = 24,
    parameter int NUM_IN      = 20,
    parameter int NUM_NEURONS = 4,
    parameter int ADDR_W      = 9
) (
    input  logic                 CLK,
    input  logic                 MasterResetN,
    neural_layer_engine_if.slave bus
);
    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] HALF    = WIDTH'(1) << (FRAC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, ACT, DONE} state_t;

    state_t           state_reg;
    logic [NW-1:0]    n_reg;
    logic [IW-1:0]    i_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             done_reg;
    logic             error_reg;
    logic [WIDTH-1:0] readdata_reg;

    logic [WIDTH-1:0] x_reg    [NUM_IN];
    logic [WIDTH-1:0] bias_reg [NUM_NEURONS];
    logic [WIDTH-1:0] w_reg    [NUM_NEURONS][NUM_IN];
    logic [WIDTH-1:0] y_reg    [NUM_NEURONS];

`ifdef NLE_RELU_EN
    logic             mode_reg;
    logic             run_mode_reg;
`endif

    // Address decode: one hit line per mapped word.
    logic [NUM_IN-1:0]             x_hit;
    logic [NUM_NEURONS-1:0]        b_hit;
    logic [NUM_NEURONS-1:0]        y_hit;
    logic [NUM_NEURONS*NUM_IN-1:0] w_hit;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_x_dec
            assign x_hit[gi] = (bus.address == ADDR_W'(32 + gi));
        end
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_n_dec
            assign b_hit[gi] = (bus.address == ADDR_W'(64 + gi));
            assign y_hit[gi] = (bus.address == ADDR_W'(128 + gi));
            for (gj = 0; gj < NUM_IN; gj++) begin : g_w_dec
                assign w_hit[gi*NUM_IN + gj] = (bus.address == ADDR_W'(256 + 32*gi + gj));
            end
        end
    endgenerate

    logic busy;
    logic ctrl_wr;
    logic clear_cmd;
    logic start_cmd;
    logic data_wr;

    assign busy      = (state_reg == LOAD) || (state_reg == MAC) || (state_reg == ACT);
    assign ctrl_wr   = bus.write && (bus.address == '0);
    // CLEAR is honoured even mid-run; START only when idle and never alongside CLEAR.
    assign clear_cmd = ctrl_wr && bus.writedata[1];
    assign start_cmd = ctrl_wr && bus.writedata[0] && !bus.writedata[1] && !busy;
    assign data_wr   = bus.write && !busy;

    // MAC datapath: full-width product, truncating shift, two saturation stages.
    logic [WIDTH-1:0]   w_sel;
    logic [WIDTH-1:0]   x_sel;
    logic [2*WIDTH-1:0] prod_full;
    logic [2*WIDTH-1:0] prod_shift;
    logic               prod_ovf;
    logic [WIDTH-1:0]   prod_sat;
    logic [WIDTH:0]     sum_full;
    logic               sum_ovf;
    logic [WIDTH-1:0]   sum_sat;

    // Product and accumulate with saturation detection.
    always_comb begin
        w_sel      = w_reg[n_reg][i_reg];
        x_sel      = x_reg[i_reg];
        prod_full  = $signed({{WIDTH{w_sel[WIDTH-1]}}, w_sel}) *
                     $signed({{WIDTH{x_sel[WIDTH-1]}}, x_sel});
        prod_shift = $signed(prod_full) >>> FRAC;
        // The shifted product fits only if everything above bit WIDTH-2 is pure sign.
        prod_ovf   = !((&prod_shift[2*WIDTH-1:WIDTH-1]) || !(|prod_shift[2*WIDTH-1:WIDTH-1]));
        prod_sat   = prod_ovf ? (prod_shift[2*WIDTH-1] ? SAT_MIN : SAT_MAX)
                              : prod_shift[WIDTH-1:0];
        sum_full   = {acc_reg[WIDTH-1], acc_reg} + {prod_sat[WIDTH-1], prod_sat};
        sum_ovf    = sum_full[WIDTH] ^ sum_full[WIDTH-1];
        sum_sat    = sum_ovf ? (sum_full[WIDTH] ? SAT_MIN : SAT_MAX) : sum_full[WIDTH-1:0];
    end

    // Activation: hard sigmoid always, ReLU only when built in.
    logic [WIDTH:0]   sig_full;
    logic [WIDTH-1:0] sig_out;
    logic [WIDTH-1:0] act_out;

    always_comb begin
        // acc>>>2 sign-extended to WIDTH+1 bits so adding one half cannot wrap.
        sig_full = {{3{acc_reg[WIDTH-1]}}, acc_reg[WIDTH-1:2]} + {1'b0, HALF};
        if (sig_full[WIDTH]) begin
            sig_out = '0;
        end else if (sig_full[WIDTH-1:0] > ONE) begin
            sig_out = ONE;
        end else begin
            sig_out = sig_full[WIDTH-1:0];
        end
`ifdef NLE_RELU_EN
        if (run_mode_reg) begin
            act_out = acc_reg[WIDTH-1] ? '0 : acc_reg;
        end else begin
            act_out = sig_out;
        end
`else
        act_out = sig_out;
`endif
    end

    // Sequencer: walks LOAD/MAC/ACT per neuron and owns y, done and error.
    always_ff @(posedge CLK or negedge MasterResetN) begin
        if (!MasterResetN) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            i_reg     <= '0;
            acc_reg   <= '0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) y_reg[k] <= '0;
`ifdef NLE_RELU_EN
            run_mode_reg <= 1'b0;
`endif
        end else if (clear_cmd) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) y_reg[k] <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start_cmd) begin
                        state_reg <= LOAD;
                        n_reg     <= '0;
                        done_reg  <= 1'b0;
                        error_reg <= 1'b0;
`ifdef NLE_RELU_EN
                        run_mode_reg <= bus.writedata[2];
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                LOAD: begin
                    acc_reg   <= bias_reg[n_reg];
                    i_reg     <= '0;
                    state_reg <= MAC;
                end
                MAC: begin
                    acc_reg <= sum_sat;
                    if (prod_ovf || sum_ovf) error_reg <= 1'b1;
                    if (i_reg == IW'(NUM_IN - 1)) begin
                        state_reg <= ACT;
                    end else begin
                        i_reg <= i_reg + 1'b1;
                    end
                end
                ACT: begin
                    y_reg[n_reg] <= act_out;
                    if (n_reg == NW'(NUM_NEURONS - 1)) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        n_reg     <= n_reg + 1'b1;
                        state_reg <= LOAD;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Parameter storage: inputs, biases and weights are frozen while a run is active.
    always_ff @(posedge CLK or negedge MasterResetN) begin
        if (!MasterResetN) begin
            for (int k = 0; k < NUM_IN; k++) x_reg[k] <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                bias_reg[n] <= '0;
                for (int k = 0; k < NUM_IN; k++) w_reg[n][k] <= '0;
            end
`ifdef NLE_RELU_EN
            mode_reg <= 1'b0;
`endif
        end else if (data_wr) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (x_hit[k]) x_reg[k] <= bus.writedata;
            end
            for (int n = 0; n < NUM_NEURONS; n++) begin
                if (b_hit[n]) bias_reg[n] <= bus.writedata;
                for (int k = 0; k < NUM_IN; k++) begin
                    if (w_hit[n*NUM_IN + k]) w_reg[n][k] <= bus.writedata;
                end
            end
`ifdef NLE_RELU_EN
            if (ctrl_wr) mode_reg <= bus.writedata[2];
`endif
        end
    end

    // Read mux; unmapped words return zero.
    logic             mode_bit;
    logic [WIDTH-1:0] rd_value;

`ifdef NLE_RELU_EN
    assign mode_bit = mode_reg;
`else
    assign mode_bit = 1'b0;
`endif

    always_comb begin
        rd_value = '0;
        if (bus.address == ADDR_W'(1)) rd_value = WIDTH'({mode_bit, error_reg, done_reg, busy});
        for (int k = 0; k < NUM_IN; k++) begin
            if (x_hit[k]) rd_value = x_reg[k];
        end
        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (b_hit[n]) rd_value = bias_reg[n];
            if (y_hit[n]) rd_value = y_reg[n];
            for (int k = 0; k < NUM_IN; k++) begin
                if (w_hit[n*NUM_IN + k]) rd_value = w_reg[n][k];
            end
        end
    end

    // Registered read data, held between read strobes.
    always_ff @(posedge CLK or negedge MasterResetN) begin
        if (!MasterResetN) begin
            readdata_reg <= '0;
        end else if (bus.read) begin
            readdata_reg <= rd_value;
        end
    end

    assign bus.readdata = readdata_reg;
    assign bus.done     = done_reg;
endmodule

// File: doc/neural_layer_engine.md
# neural_layer_engine

Parametrised, bus-mapped fully-connected neural layer. It evaluates `NUM_NEURONS` neurons over a shared input vector of `NUM_IN` signed fixed-point values. Each neuron output is `act(bias[n] + Σ w[n][i]·x[i])`. A single time-multiplexed MAC and one activation unit are shared by all neurons. The block sits on the CPU slave bus in place of the single-neuron datapath, with a sticky error flag and a done status.

## Interface
Parameters:
- `WIDTH`, 32: data width; signed two's complement.
- `FRAC`, 24: fractional bits. 1.0 = `1<<FRAC`.
- `NUM_IN`, 20: inputs per neuron, 1..32.
- `NUM_NEURONS`, 4: neurons in the layer, 1..8.
- `ADDR_W`, 9: bus address width.

Ports:
- `CLK`  in  1  single clock; everything is on the rising edge.
- `MasterResetN`  in  1  asynchronous, active-low reset.
- `write`  in  1  bus write strobe, one cycle.
- `read`  in  1  bus read strobe, one cycle.
- `address`  in  `ADDR_W`  word address.
- `writedata`  in  `WIDTH`  write data.
- `readdata`  out  `WIDTH`  registered read data.
- `done`  out  1  level; high from layer completion until the next start or clear.

## Operation
- Address map:
  - 0x000 CTRL (write-only). bit0 START: self-clearing pulse. bit1 CLEAR: clears done, error and outputs. bit2 MODE: see Configuration.
  - 0x001 STATUS (read-only). bit0 busy, bit1 done, bit2 error (sticky). Other bits read 0.
  - 0x020+i: x[i].
  - 0x040+n: bias[n].
  - 0x080+n: y[n], read-only.
  - 0x100+32n+i: w[n][i].
- Unmapped addresses read 0. Writes to unmapped addresses are ignored.
- All storage resets to 0.
- While busy, all writes to x, w, bias and CTRL are ignored, except CLEAR.
- CLEAR while busy aborts the run, returns to IDLE, and zeroes done, error and y.
- FSM states: IDLE, LOAD, MAC, ACT, DONE.
  - IDLE: START → LOAD with n=0; done drops.
  - LOAD: acc ← bias[n]; i=0.
  - MAC: one product per cycle, `acc ← sat(acc + sat((w[n][i]·x[i])>>>FRAC))`. When i=NUM_IN-1 → ACT.
  - ACT: y[n] ← act(acc). If n=NUM_NEURONS-1 → DONE, else n+1 → LOAD.
  - DONE: done=1, busy=0; next cycle → IDLE with done held.
- Arithmetic:
  - The product is the full 2·WIDTH result, arithmetically shifted right by FRAC (truncation).
  - Saturation limits are 0x7FFF_FFFF and 0x8000_0000 (scaled to WIDTH).
  - Any saturation, in the product or the accumulate, sets error. Error stays set until CLEAR or START.
- Default activation is the hard sigmoid: `y = clamp((acc>>>2) + (1<<(FRAC-1)), 0, 1<<FRAC)`.

## Timing
- Reset values: readdata=0, done=0, busy=0, error=0, state=IDLE.
- Reads have 1-cycle latency: readdata is valid the cycle after `read`. readdata holds its value when `read` is low.
- A read and a write in the same cycle to the same address return the old value.
- START is written in cycle 0. LOAD occurs in cycle 1. done rises at cycle `NUM_NEURONS·(NUM_IN+2)+1`.
- START while busy is ignored. START and CLEAR in the same write: CLEAR wins, and no run begins.
- Reset asserted mid-run forces IDLE and zeroes all registers immediately. This does not wait for a clock edge.
- y[n] is readable as soon as its ACT cycle completes, including while busy.

## Configuration
- `NLE_RELU_EN` defined:
  - CTRL bit2 is stored (reset 0).
  - With MODE=1, `act(acc) = (acc<0) ? 0 : acc`, with no clamp.
  - MODE is sampled at START and held for the whole run.
  - STATUS bit3 reads back MODE.
- `NLE_RELU_EN` undefined:
  - CTRL bit2 is ignored, and STATUS bit3 reads 0.
  - Only the hard sigmoid is built, and no ReLU logic is synthesised.

## Test plan
The bench uses NUM_IN=4, NUM_NEURONS=2, FRAC=24.
- **Basic run:** w[0][*]=0x01000000, x[*]=0x00800000, bias[0]=0; w[1][*]=0, bias[1]=0xFF000000; START → done at cycle 13, y[0]=0x01000000, y[1]=0x00400000, error=0.
- **Saturation:** w[0][*]=x[*]=0x7FFFFFFF → STATUS=0b110, y[0]=0x01000000. A following START clears error.
- **Writes while busy:** START, then during MAC write START and w[0][0]=0x12345678 → both ignored; w[0][0] reads its prior value, and done still rises at cycle 13.
- **Reset mid-run:** MasterResetN low for 1 cycle during MAC → STATUS=0, y[*]=0, weights=0, and readdata=0 on the next read.
- **CLEAR:** CLEAR during MAC → busy=0 next cycle, done=0, y=0, weights retained.
- **ReLU mode (`NLE_RELU_EN`):** MODE=1 with the basic-run data → y[0]=0x02000000, y[1]=0. Without the macro the same stimulus gives the sigmoid results above.
